// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the two-port ALU arbiter.
//   DEF_WIDTH  default operand/result width
//   state_e    arbiter FSM states
//   OP_ADD/SUB operation codes (match the ALU inst_id encoding)
package alu_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_component.sv
// alu_component: shared combinational add/subtract ALU driven by alu_arbiter.
//   inst_id  in   0 = add, 1 = subtract (in0 - in1)
//   in0/in1  in   operands
//   out      out  result modulo 2^WIDTH
//   zero     out  bit 0 set when result is zero
//   pos      out  bit 0 set when result is nonzero with MSB clear
module alu_component
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             inst_id,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] zero,
  output logic [WIDTH-1:0] pos
);

  assign out  = (inst_id == OP_SUB) ? (in0 - in1) : (in0 + in1);
  assign zero = WIDTH'(out == '0);
  assign pos  = WIDTH'((out != '0) && !out[WIDTH-1]);

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way winner select.
//   req0_i/req1_i  in   requests
//   last_grant_i   in   port granted most recently
//   gnt_o          out  winning port (0/1), meaningful when any_o is high
//   any_o          out  at least one request is high
module rr_arb2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_o,
  output logic any_o
);

  // On conflict, round-robin favours the port not served last; fixed mode favours port 0.
  always_comb begin
    any_o = req0_i | req1_i;
    gnt_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt_o = ROUND_ROBIN ? ~last_grant_i : 1'b0;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external add/subtract ALU between two requesters.
//   clk, reset               clock, async active-high reset
//   req*/op*/a*/b*           per-port request, operation and operands
//   done0/done1              one-cycle completion pulse to the served port
//   res_data/zero/pos        captured result and flags, held between operations
//   busy                     high while an operation is in flight
//   alu_inst_id/in0/in1      registered ALU drive
//   alu_out/zero/pos         ALU response
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_pos,
  output logic             busy,
  output logic             alu_inst_id,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_zero,
  input  logic [WIDTH-1:0] alu_pos
);

  state_e           state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic             done0_q, done1_q, busy_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_zero_q, res_pos_q;
  logic             alu_inst_id_q;
  logic [WIDTH-1:0] alu_in0_q, alu_in1_q;
  logic             arb_gnt, arb_any;

  // Only bit 0 of the ALU flag buses carries information.
  logic             unused_flag_bits;
  assign unused_flag_bits = ^{alu_zero[WIDTH-1:1], alu_pos[WIDTH-1:1]};

  rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .any_o        (arb_any)
  );

  // Grant / issue / respond sequencer; requests are only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      busy_q        <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_pos_q     <= 1'b0;
      alu_inst_id_q <= 1'b0;
      alu_in0_q     <= '0;
      alu_in1_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            alu_inst_id_q <= arb_gnt ? op1 : op0;
            alu_in0_q     <= arb_gnt ? a1 : a0;
            alu_in1_q     <= arb_gnt ? b1 : b0;
            grant_q       <= arb_gnt;
            last_grant_q  <= arb_gnt;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          res_data_q <= alu_out;
          res_zero_q <= alu_zero[0];
          res_pos_q  <= alu_pos[0];
          // done is registered here so it is high exactly during RESP
          done0_q    <= ~grant_q;
          done1_q    <= grant_q;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign busy        = busy_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_pos     = res_pos_q;
  assign alu_inst_id = alu_inst_id_q;
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (round-robin and fixed priority) each with its own ALU,
// checked by a transaction-level model and a result scoreboard.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
    logic         pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index [k][p]: k = instance (0 round-robin, 1 fixed), p = port
  logic         req [2][2];
  logic         op  [2][2];
  logic [W-1:0] a   [2][2];
  logic [W-1:0] b   [2][2];
  logic         done [2][2];
  logic         busy [2];
  logic [W-1:0] res_data [2];
  logic         res_zero [2];
  logic         res_pos  [2];
  logic         alu_inst_id [2];
  logic [W-1:0] alu_in0 [2];
  logic [W-1:0] alu_in1 [2];
  logic [W-1:0] alu_out [2];
  logic [W-1:0] alu_zero [2];
  logic [W-1:0] alu_pos  [2];

  alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req[0][0]), .req1(req[0][1]), .op0(op[0][0]), .op1(op[0][1]),
    .a0(a[0][0]), .b0(b[0][0]), .a1(a[0][1]), .b1(b[0][1]),
    .done0(done[0][0]), .done1(done[0][1]),
    .res_data(res_data[0]), .res_zero(res_zero[0]), .res_pos(res_pos[0]), .busy(busy[0]),
    .alu_inst_id(alu_inst_id[0]), .alu_in0(alu_in0[0]), .alu_in1(alu_in1[0]),
    .alu_out(alu_out[0]), .alu_zero(alu_zero[0]), .alu_pos(alu_pos[0])
  );
  alu_component #(.WIDTH(W)) alu_rr (
    .inst_id(alu_inst_id[0]), .in0(alu_in0[0]), .in1(alu_in1[0]),
    .out(alu_out[0]), .zero(alu_zero[0]), .pos(alu_pos[0])
  );

  alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req[1][0]), .req1(req[1][1]), .op0(op[1][0]), .op1(op[1][1]),
    .a0(a[1][0]), .b0(b[1][0]), .a1(a[1][1]), .b1(b[1][1]),
    .done0(done[1][0]), .done1(done[1][1]),
    .res_data(res_data[1]), .res_zero(res_zero[1]), .res_pos(res_pos[1]), .busy(busy[1]),
    .alu_inst_id(alu_inst_id[1]), .alu_in0(alu_in0[1]), .alu_in1(alu_in1[1]),
    .alu_out(alu_out[1]), .alu_zero(alu_zero[1]), .alu_pos(alu_pos[1])
  );
  alu_component #(.WIDTH(W)) alu_fp (
    .inst_id(alu_inst_id[1]), .in0(alu_in0[1]), .in1(alu_in1[1]),
    .out(alu_out[1]), .zero(alu_zero[1]), .pos(alu_pos[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic exp_t ref_alu(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    int unsigned m;
    exp_t e;
    m = 32'd1 << W;
    if (o == OP_SUB) r = (int'(x) + m - int'(y)) % m;
    else             r = (int'(x) + int'(y)) % m;
    e.data = W'(r);
    e.zero = (r == 0);
    e.pos  = (r != 0) && (r < (m >> 1));
    return e;
  endfunction

  // Transaction-level model state per instance.
  int   cnt   [2];   // cycles of the current operation still to run
  int   gport [2];
  int   last  [2];
  logic         m_op [2];
  logic [W-1:0] m_a  [2];
  logic [W-1:0] m_b  [2];
  exp_t m_exp  [2];
  exp_t held   [2];
  exp_t exp_q  [4][$];

  function automatic int pick(input int k, input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    return (k == 0) ? 1 - last[k] : 0;
  endfunction

  // Model: predicts busy/done/ALU drive/held result each cycle and pushes expected results at grant.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        chk("rst_done0", k, 32'(done[k][0]), 32'd0);
        chk("rst_done1", k, 32'(done[k][1]), 32'd0);
        chk("rst_busy", k, 32'(busy[k]), 32'd0);
        chk("rst_res", k, 32'({res_data[k], res_zero[k], res_pos[k]}), 32'd0);
        chk("rst_alu", k, 32'({alu_inst_id[k], alu_in0[k], alu_in1[k]}), 32'd0);
        cnt[k]  = 0;
        last[k] = 1;
        held[k] = '0;
        exp_q[2*k].delete();
        exp_q[2*k+1].delete();
      end else begin
        if (cnt[k] == 1) held[k] = m_exp[k];
        chk("busy", k, 32'(busy[k]), 32'(cnt[k] > 0));
        chk("done0", k, 32'(done[k][0]), 32'(cnt[k] == 1 && gport[k] == 0));
        chk("done1", k, 32'(done[k][1]), 32'(cnt[k] == 1 && gport[k] == 1));
        chk("res_held", k, 32'({res_data[k], res_zero[k], res_pos[k]}), 32'(held[k]));
        if (cnt[k] == 2) begin
          chk("alu_drive", k, 32'({alu_inst_id[k], alu_in0[k], alu_in1[k]}),
              32'({m_op[k], m_a[k], m_b[k]}));
        end
        if (cnt[k] > 0) begin
          cnt[k]--;
        end else if (req[k][0] || req[k][1]) begin
          int w;
          w        = pick(k, req[k][0], req[k][1]);
          gport[k] = w;
          last[k]  = w;
          cnt[k]   = 2;
          m_op[k]  = op[k][w];
          m_a[k]   = a[k][w];
          m_b[k]   = b[k][w];
          m_exp[k] = ref_alu(op[k][w], a[k][w], b[k][w]);
          exp_q[2*k+w].push_back(m_exp[k]);
        end
      end
    end
  end

  // Monitor: on every done pulse, pop that port's expected result and compare.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (done[k][p] === 1'b1) begin
            if (exp_q[2*k+p].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected_done inst%0d port%0d t=%0t: got done with nothing expected", k, p, $time);
            end else begin
              exp_t e;
              e = exp_q[2*k+p].pop_front();
              chk("sb_data", k, 32'(res_data[k]), 32'(e.data));
              chk("sb_zero", k, 32'(res_zero[k]), 32'(e.zero));
              chk("sb_pos", k, 32'(res_pos[k]), 32'(e.pos));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int p, input logic r, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < 2; k++) begin
      req[k][p] = r;
      op[k][p]  = o;
      a[k][p]   = x;
      b[k][p]   = y;
    end
  endtask

  task automatic wait_done(input int p, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (done[0][p] === 1'b1) seen = 1'b1;
    end
    chk(nm, 0, 32'(seen), 32'd1);
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic new_op(input int k, input int p);
    req[k][p] = 1'b1;
    op[k][p]  = 1'($urandom_range(0, 1));
    a[k][p]   = rand_val();
    b[k][p]   = ($urandom_range(0, 5) == 0) ? a[k][p] : rand_val();
  endtask

  // Random requester: holds req until its done, then either re-issues or drops.
  task automatic agent(input int k, input int p, input int n);
    for (int c = 0; c < n; c++) begin
      tick(1);
      if (req[k][p] && done[k][p]) begin
        if ($urandom_range(0, 3) == 0) new_op(k, p);
        else req[k][p] = 1'b0;
      end else if (!req[k][p] && $urandom_range(0, 2) == 0) begin
        new_op(k, p);
      end
    end
    req[k][p] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0;
        op[k][p]  = 1'b0;
        a[k][p]   = '0;
        b[k][p]   = '0;
      end
    end
    tick(3);
    reset = 1'b0;
    tick(1);

    // single add on port 0
    drive(0, 1'b1, OP_ADD, 16'h0005, 16'h0003);
    wait_done(0, "wait_add");
    chk("add_res", 0, 32'({res_data[0], res_zero[0], res_pos[0]}), 32'({16'h0008, 1'b0, 1'b1}));
    chk("add_idle_done1", 0, 32'(done[0][1]), 32'd0);
    drive(0, 1'b0, OP_ADD, 16'h0005, 16'h0003);
    tick(1);

    // negative subtract on port 1
    drive(1, 1'b1, OP_SUB, 16'h0002, 16'h0007);
    wait_done(1, "wait_sub_neg");
    chk("sub_neg_res", 0, 32'({res_data[0], res_zero[0], res_pos[0]}), 32'({16'hFFFB, 1'b0, 1'b0}));
    drive(1, 1'b0, OP_SUB, 16'h0002, 16'h0007);
    tick(1);

    // zero subtract on port 1
    drive(1, 1'b1, OP_SUB, 16'h1234, 16'h1234);
    wait_done(1, "wait_sub_zero");
    chk("sub_zero_res", 0, 32'({res_data[0], res_zero[0], res_pos[0]}), 32'({16'h0000, 1'b1, 1'b0}));
    drive(1, 1'b0, OP_SUB, 16'h1234, 16'h1234);
    tick(1);

    // operand change after grant is ignored
    drive(0, 1'b1, OP_ADD, 16'h1000, 16'h0001);
    tick(1);
    for (int k = 0; k < 2; k++) a[k][0] = 16'h7777;
    wait_done(0, "wait_latch");
    chk("latch_res", 0, 32'(res_data[0]), 32'h1001);
    drive(0, 1'b0, OP_ADD, 16'h0000, 16'h0000);
    tick(1);

    // reset during ISSUE, then re-arbitrate the held request
    drive(0, 1'b1, OP_SUB, 16'h0100, 16'h0001);
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wait_done(0, "wait_after_reset");
    chk("after_reset_res", 0, 32'(res_data[0]), 32'h00FF);
    drive(0, 1'b0, OP_SUB, 16'h0100, 16'h0001);
    tick(1);

    // both ports held from reset, then port 0 drops
    reset = 1'b1;
    drive(0, 1'b1, OP_ADD, 16'h0101, 16'h0202);
    drive(1, 1'b1, OP_SUB, 16'h0050, 16'h0060);
    tick(2);
    reset = 1'b0;
    tick(13);
    drive(0, 1'b0, OP_ADD, 16'h0101, 16'h0202);
    tick(7);
    drive(1, 1'b0, OP_SUB, 16'h0050, 16'h0060);
    tick(4);

    // randomized traffic on all four ports
    fork
      agent(0, 0, 600);
      agent(0, 1, 600);
      agent(1, 0, 600);
      agent(1, 1, 600);
    join
    tick(8);

    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        chk("sb_drained", k, 32'(exp_q[2*k+p].size()), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
